// File: rtl/crop_pkg.sv
// -----------------------------------------------------------------------------
// crop_pkg
//  Shared definitions for the crop_window block and its raster counter.
//  Contents:
//    H_ACT_DEF / V_ACT_DEF  default active raster size (640x480)
//    crop_state_t           vertical window state (before / inside / after)
//    clamp_xstart()         limits a detected left edge so the window fits
// -----------------------------------------------------------------------------
package crop_pkg;

    localparam int H_ACT_DEF = 640;
    localparam int V_ACT_DEF = 480;

    typedef enum logic [1:0] {
        S_PRE  = 2'd0,
        S_WIN  = 2'd1,
        S_POST = 2'd2
    } crop_state_t;

    // Largest legal left edge is lineWidth - cropWidth; anything beyond is pulled back.
    function automatic logic [15:0] clamp_xstart(
        input logic [15:0] xs,
        input logic [15:0] w,
        input logic [15:0] h
    );
        logic [15:0] lim;
        lim = h - w;
        if (xs > lim) begin
            return lim;
        end else begin
            return xs;
        end
    endfunction

endpackage

// File: rtl/crop_window_if.sv
// -----------------------------------------------------------------------------
// crop_window_if
//  Pixel stream bundle around crop_window.
//  Source side (master): iDVAL, iDATA[DW], iXSTART[16]
//  Cropped side (slave drives): oDVAL, oDATA[DW], oX[16], oY[16], oFRAME_DONE
//  With CROP_PIXCNT_EN defined an extra oPIXCNT[20] is carried.
// -----------------------------------------------------------------------------
interface crop_window_if #(
    parameter int DW = 10
);
    logic          iDVAL;
    logic [DW-1:0] iDATA;
    logic [15:0]   iXSTART;
    logic          oDVAL;
    logic [DW-1:0] oDATA;
    logic [15:0]   oX;
    logic [15:0]   oY;
    logic          oFRAME_DONE;
`ifdef CROP_PIXCNT_EN
    logic [19:0]   oPIXCNT;

    modport master (
        output iDVAL, iDATA, iXSTART,
        input  oDVAL, oDATA, oX, oY, oFRAME_DONE, oPIXCNT
    );
    modport slave (
        input  iDVAL, iDATA, iXSTART,
        output oDVAL, oDATA, oX, oY, oFRAME_DONE, oPIXCNT
    );
`else
    modport master (
        output iDVAL, iDATA, iXSTART,
        input  oDVAL, oDATA, oX, oY, oFRAME_DONE
    );
    modport slave (
        input  iDVAL, iDATA, iXSTART,
        output oDVAL, oDATA, oX, oY, oFRAME_DONE
    );
`endif
endinterface

// File: rtl/crop_raster_counter.sv
// -----------------------------------------------------------------------------
// crop_raster_counter
//  Tracks the raster position of the current input pixel. Counters advance
//  only on valid pixels; there are no sync inputs, so the first valid pixel
//  after reset is (0,0).
//  Ports:
//    iCLK, iRST (async active-low), iDVAL
//    x, y        position of the pixel presented this cycle
//    frameStart  pixel is (0,0)
//    lineEnd     pixel is the last of its line
//    frameEnd    pixel is the last of the frame
// -----------------------------------------------------------------------------
module crop_raster_counter
    import crop_pkg::*;
#(
    parameter int H_ACT = H_ACT_DEF,
    parameter int V_ACT = V_ACT_DEF
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iDVAL,
    output logic [15:0] x,
    output logic [15:0] y,
    output logic        frameStart,
    output logic        lineEnd,
    output logic        frameEnd
);
    localparam logic [15:0] X_LAST = 16'(H_ACT - 1);
    localparam logic [15:0] Y_LAST = 16'(V_ACT - 1);

    logic [15:0] xR;
    logic [15:0] yR;

    // Raster position, stepped once per valid pixel with line and frame wrap.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            xR <= 16'd0;
            yR <= 16'd0;
        end else if (iDVAL) begin
            if (xR == X_LAST) begin
                xR <= 16'd0;
                if (yR == Y_LAST) begin
                    yR <= 16'd0;
                end else begin
                    yR <= yR + 16'd1;
                end
            end else begin
                xR <= xR + 16'd1;
            end
        end else begin
            xR <= xR;
            yR <= yR;
        end
    end

    assign x          = xR;
    assign y          = yR;
    assign frameStart = (xR == 16'd0) && (yR == 16'd0);
    assign lineEnd    = (xR == X_LAST);
    assign frameEnd   = (xR == X_LAST) && (yR == Y_LAST);

endmodule

// File: rtl/crop_window.sv
// -----------------------------------------------------------------------------
// crop_window
//  Passes only the pixels of a CROP_W x CROP_H window whose left edge is the
//  X-start latched at the first pixel of each frame and whose top line is
//  Y_START. Output is registered one cycle after the input pixel and carries
//  the in-window column/row.
//  Ports:
//    iCLK  pixel clock
//    iRST  asynchronous active-low reset
//    bus   crop_window_if.slave (iDVAL/iDATA/iXSTART in, oDVAL/oDATA/oX/oY/
//          oFRAME_DONE out)
//  Optional feature macro: CROP_PIXCNT_EN -> bus.oPIXCNT, number of pixels
//  emitted in the frame, updated together with oFRAME_DONE.
// -----------------------------------------------------------------------------
module crop_window
    import crop_pkg::*;
#(
    parameter int DW      = 10,
    parameter int H_ACT   = H_ACT_DEF,
    parameter int V_ACT   = V_ACT_DEF,
    parameter int CROP_W  = 320,
    parameter int CROP_H  = 240,
    parameter int Y_START = 50
) (
    input  logic         iCLK,
    input  logic         iRST,
    crop_window_if.slave bus
);
    localparam logic [15:0] H_ACT16    = 16'(H_ACT);
    localparam logic [15:0] CW16       = 16'(CROP_W);
    localparam logic [15:0] CH16       = 16'(CROP_H);
    localparam logic [15:0] YS16       = 16'(Y_START);
    localparam logic [15:0] XS_RST     = 16'((H_ACT - CROP_W) / 2);
    localparam logic [15:0] WIN_LAST_Y = 16'(Y_START + CROP_H - 1);
    localparam logic [15:0] PRE_LAST_Y = (Y_START > 0) ? 16'(Y_START - 1) : 16'd0;
    // Window starting on line 0 is entered at the frame wrap; window ending on
    // the last line leaves at the frame wrap.
    localparam logic ENTRY_AT_WRAP = (Y_START == 0) ? 1'b1 : 1'b0;
    localparam logic EXIT_AT_WRAP  = ((Y_START + CROP_H) == V_ACT) ? 1'b1 : 1'b0;

    logic [15:0]   rasterX;
    logic [15:0]   rasterY;
    logic          frameStart;
    logic          lineEnd;
    logic          frameEnd;

    logic [15:0]   xsAct;
    crop_state_t   state;

    logic          inWin;
    logic          lastPix;
    logic          enterWin;
    logic [15:0]   relX;
    logic [15:0]   relY;

    logic          oDvalR;
    logic [DW-1:0] oDataR;
    logic [15:0]   oXR;
    logic [15:0]   oYR;
    logic          oDoneR;

    crop_raster_counter #(
        .H_ACT (H_ACT),
        .V_ACT (V_ACT)
    ) u_raster (
        .iCLK       (iCLK),
        .iRST       (iRST),
        .iDVAL      (bus.iDVAL),
        .x          (rasterX),
        .y          (rasterY),
        .frameStart (frameStart),
        .lineEnd    (lineEnd),
        .frameEnd   (frameEnd)
    );

    // Window membership and in-window coordinates of the current pixel.
    // xsAct is a register, so a frame-wrap pixel still sees the previous edge.
    always_comb begin
        relX     = rasterX - xsAct;
        relY     = rasterY - YS16;
        inWin    = 1'b0;
        lastPix  = 1'b0;
        enterWin = 1'b0;
        if ((state == S_WIN) && (rasterX >= xsAct) && (rasterX < (xsAct + CW16))) begin
            inWin = 1'b1;
        end else begin
            inWin = 1'b0;
        end
        if (inWin && (relX == (CW16 - 16'd1)) && (relY == (CH16 - 16'd1))) begin
            lastPix = 1'b1;
        end else begin
            lastPix = 1'b0;
        end
        if (ENTRY_AT_WRAP) begin
            enterWin = frameEnd;
        end else begin
            enterWin = lineEnd && (rasterY == PRE_LAST_Y);
        end
    end

    // Left edge for this frame, captured only on the (0,0) pixel.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            xsAct <= XS_RST;
        end else if (bus.iDVAL && frameStart) begin
            xsAct <= clamp_xstart(bus.iXSTART, CW16, H_ACT16);
        end else begin
            xsAct <= xsAct;
        end
    end

    // Vertical window state machine, stepped on valid pixels.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state <= S_PRE;
        end else if (bus.iDVAL) begin
            case (state)
                S_PRE: begin
                    if (enterWin) begin
                        state <= S_WIN;
                    end else begin
                        state <= S_PRE;
                    end
                end
                S_WIN: begin
                    if (lineEnd && (rasterY == WIN_LAST_Y)) begin
                        if (EXIT_AT_WRAP && ENTRY_AT_WRAP) begin
                            state <= S_WIN;
                        end else if (EXIT_AT_WRAP) begin
                            state <= S_PRE;
                        end else begin
                            state <= S_POST;
                        end
                    end else begin
                        state <= S_WIN;
                    end
                end
                S_POST: begin
                    if (frameEnd) begin
                        state <= ENTRY_AT_WRAP ? S_WIN : S_PRE;
                    end else begin
                        state <= S_POST;
                    end
                end
                default: begin
                    state <= S_PRE;
                end
            endcase
        end else begin
            state <= state;
        end
    end

    // Registered output stream; data and coordinates hold between window pixels.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            oDvalR <= 1'b0;
            oDataR <= '0;
            oXR    <= 16'd0;
            oYR    <= 16'd0;
            oDoneR <= 1'b0;
        end else begin
            oDvalR <= bus.iDVAL && inWin;
            oDoneR <= bus.iDVAL && lastPix;
            if (bus.iDVAL && inWin) begin
                oDataR <= bus.iDATA;
                oXR    <= relX;
                oYR    <= relY;
            end else begin
                oDataR <= oDataR;
                oXR    <= oXR;
                oYR    <= oYR;
            end
        end
    end

    assign bus.oDVAL       = oDvalR;
    assign bus.oDATA       = oDataR;
    assign bus.oX          = oXR;
    assign bus.oY          = oYR;
    assign bus.oFRAME_DONE = oDoneR;

`ifdef CROP_PIXCNT_EN
    logic [19:0] pixCnt;
    logic [19:0] pixCntNext;
    logic [19:0] oPixCntR;

    // Running count including the pixel presented this cycle.
    always_comb begin
        pixCntNext = pixCnt;
        if (inWin) begin
            pixCntNext = pixCnt + 20'd1;
        end else begin
            pixCntNext = pixCnt;
        end
    end

    // Per-frame emitted-pixel count, published on the last window pixel.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            pixCnt   <= 20'd0;
            oPixCntR <= 20'd0;
        end else if (bus.iDVAL) begin
            if (lastPix) begin
                oPixCntR <= pixCntNext;
            end else begin
                oPixCntR <= oPixCntR;
            end
            if (frameEnd) begin
                pixCnt <= 20'd0;
            end else begin
                pixCnt <= pixCntNext;
            end
        end else begin
            pixCnt   <= pixCnt;
            oPixCntR <= oPixCntR;
        end
    end

    assign bus.oPIXCNT = oPixCntR;
`endif

endmodule

// File: tb/tb_crop_window.sv
// -----------------------------------------------------------------------------
// tb_crop_window
//  Randomized stream bench for crop_window on a reduced raster (64x24, 32x12
//  window from line 5). A reference model tracks raster position and the
//  per-frame window; expected output pixels are queued when driven and
//  compared by a monitor when the DUT presents oDVAL.
// -----------------------------------------------------------------------------
module tb_crop_window;
    localparam int DW     = 10;
    localparam int H      = 64;
    localparam int V      = 24;
    localparam int CW     = 32;
    localparam int CH     = 12;
    localparam int YS     = 5;
    localparam int FR     = H * V;
    localparam int XS_MAX = H - CW;
    localparam int XS_RST = (H - CW) / 2;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [15:0]   x;
        logic [15:0]   y;
        logic          done;
        logic [19:0]   cnt;
        logic [31:0]   cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rstN;
    always #5 clk = ~clk;

    crop_window_if #(.DW(DW)) bus();

    crop_window #(
        .DW(DW), .H_ACT(H), .V_ACT(V), .CROP_W(CW), .CROP_H(CH), .Y_START(YS)
    ) dut (
        .iCLK (clk),
        .iRST (rstN),
        .bus  (bus)
    );

    exp_t        sbq[$];
    int          nChecks = 0;
    int          nFails  = 0;
    int unsigned cyc     = 0;
    logic        prevDval = 1'b0;
    bit          monOn   = 1'b0;

    int mx, my, mxs, mcnt, xsIn;
    int framesDone = 0;
    int doneSeen   = 0;
    logic [DW-1:0] lastData;
    logic [15:0]   lastX, lastY;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        prevDval <= bus.iDVAL;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: window is lines YS..YS+CH-1, columns xs..xs+CW-1 where
    // xs is min(iXSTART, H-CW) sampled at the frame's first pixel.
    task automatic modelPixel(input logic [DW-1:0] d);
        exp_t e;
        if (mx == 0 && my == 0) begin
            mxs  = (xsIn > XS_MAX) ? XS_MAX : xsIn;
            mcnt = 0;
        end
        if (my >= YS && my < YS + CH && mx >= mxs && mx < mxs + CW) begin
            mcnt++;
            e.data = d;
            e.x    = 16'(mx - mxs);
            e.y    = 16'(my - YS);
            e.done = ((mx - mxs) == CW - 1) && ((my - YS) == CH - 1);
            e.cnt  = 20'(mcnt);
            e.cyc  = cyc + 1;
            if (e.done) framesDone++;
            sbq.push_back(e);
        end
        mx++;
        if (mx == H) begin
            mx = 0;
            my++;
            if (my == V) my = 0;
        end
    endtask

    task automatic step(input bit dv);
        logic [DW-1:0] d;
        @(negedge clk);
        d = DW'($urandom);
        bus.iDVAL   = dv;
        bus.iDATA   = d;
        bus.iXSTART = 16'(xsIn);
        if (dv) modelPixel(d);
    endtask

    task automatic doReset();
        @(posedge clk);
        #2;
        rstN = 1'b0;
        sbq.delete();
        mx = 0; my = 0; mxs = XS_RST; mcnt = 0;
        lastData = '0; lastX = 16'd0; lastY = 16'd0;
        #1;
        check("rst_mid_dval", bus.oDVAL, 0);
        check("rst_mid_x", bus.oX, 0);
        check("rst_mid_y", bus.oY, 0);
        check("rst_mid_data", bus.oDATA, 0);
        check("rst_mid_done", bus.oFRAME_DONE, 0);
        bus.iDVAL = 1'b0;
        repeat (2) @(negedge clk);
        rstN = 1'b1;
    endtask

    // Monitor: pop and compare on every output pixel, check holds otherwise.
    always @(negedge clk) begin
        exp_t e;
        if (monOn) begin
            if (bus.oDVAL) begin
                check("dval_after_idle", prevDval, 1);
                if (sbq.size() == 0) begin
                    nChecks++;
                    nFails++;
                    $display("FAIL unexpected_pixel: got x=%0d y=%0d expected none", bus.oX, bus.oY);
                end else begin
                    e = sbq.pop_front();
                    check("latency_cycle", cyc, e.cyc);
                    check("pix_data", bus.oDATA, e.data);
                    check("pix_x", bus.oX, e.x);
                    check("pix_y", bus.oY, e.y);
                    check("frame_done", bus.oFRAME_DONE, e.done);
`ifdef CROP_PIXCNT_EN
                    if (e.done) check("pixcnt", bus.oPIXCNT, e.cnt);
`endif
                    if (bus.oFRAME_DONE) doneSeen++;
                    lastData = e.data;
                    lastX    = e.x;
                    lastY    = e.y;
                end
            end else begin
                check("idle_done_low", bus.oFRAME_DONE, 0);
                check("hold_x", bus.oX, lastX);
                check("hold_y", bus.oY, lastY);
                check("hold_data", bus.oDATA, lastData);
            end
        end
    end

    initial begin
        rstN        = 1'b0;
        bus.iDVAL   = 1'b0;
        bus.iDATA   = '0;
        bus.iXSTART = 16'd0;
        xsIn = 0;
        mx = 0; my = 0; mxs = XS_RST; mcnt = 0;
        lastData = '0; lastX = 16'd0; lastY = 16'd0;
        repeat (3) @(negedge clk);
        check("reset_dval", bus.oDVAL, 0);
        check("reset_data", bus.oDATA, 0);
        check("reset_x", bus.oX, 0);
        check("reset_y", bus.oY, 0);
        check("reset_done", bus.oFRAME_DONE, 0);
`ifdef CROP_PIXCNT_EN
        check("reset_pixcnt", bus.oPIXCNT, 0);
`endif
        rstN  = 1'b1;
        monOn = 1'b1;

        // Continuous stream, left edge 20.
        xsIn = 20;
        repeat (2 * FR) step(1'b1);
        // Left edge beyond the line: clamped to H-CW.
        xsIn = 50;
        repeat (FR) step(1'b1);
        // Mid-frame edge change only takes effect next frame.
        xsIn = 20;
        repeat (FR / 2) step(1'b1);
        xsIn = 10;
        repeat (FR + FR / 2) step(1'b1);
        // Edge at zero.
        xsIn = 0;
        repeat (FR) step(1'b1);
        // Alternating valid.
        xsIn = int'($urandom_range(0, 40));
        repeat (FR) begin
            step(1'b1);
            step(1'b0);
        end
        // Random valid and constantly changing edge request.
        repeat (3 * FR) begin
            xsIn = int'($urandom_range(0, 63));
            step($urandom_range(0, 3) != 0);
        end
        // Reset inside the window, then resume.
        for (int k = 0; k < 2 * FR && !(my == 8 && mx == 30); k++) step(1'b1);
        doReset();
        xsIn = 7;
        repeat (2 * FR) step($urandom_range(0, 3) != 0);
        repeat (4) step(1'b0);

        check("sb_drained", sbq.size(), 0);
        check("frames_done_count", doneSeen, framesDone);
        monOn = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
